ife_commit_sequencer: RTL

//  Downstream of the IFE commit/compare stage. Consumes its per-block verdict (commit_ok / commit_fail).
//  On ok: snapshots the agreed register vector and writes it into the architectural register file,
//  one register per cycle. On fail: requests serial re-execution of the block, waits for the

---
 rtl/ife_pkg.sv | 21 ++
 rtl/ife_reg_snapshot.sv | 31 +++
 rtl/ife_commit_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ife_pkg.sv
// ife_pkg: shared types for the IFE commit sequencer.
//   ife_cseq_state_t : sequencer FSM states
//   REG_IDX_W        : register-index width for the default 32-entry register file
//   idx_width()      : register-index width for an arbitrary register count
package ife_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    SREQ,
    SWAIT,
    DONE
  } ife_cseq_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned REG_IDX_W = idx_width(32);

endpackage

// File: rtl/ife_reg_snapshot.sv
// ife_reg_snapshot: NUM_REGS x REG_WIDTH holding buffer for one block's register vector.
//   clk       : clock
//   load      : replace the whole buffer with load_data on this edge
//   load_data : full register vector
//   rd_idx    : combinational read index
//   rd_data   : buffered register at rd_idx
// The buffer has no reset; its contents are only meaningful after a load.
module ife_reg_snapshot
  import ife_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned REG_WIDTH = 64
) (
  input  logic                                clk,
  input  logic                                load,
  input  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  load_data,
  input  logic [idx_width(NUM_REGS)-1:0]      rd_idx,
  output logic [REG_WIDTH-1:0]                rd_data
);

  logic [NUM_REGS-1:0][REG_WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (load) begin
      mem <= load_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ife_commit_sequencer.sv
// ife_commit_sequencer: retires IFE blocks after the commit/compare stage.
//   ok verdict   : snapshot result_in, write x1..x(NUM_REGS-1) one per cycle, retire.
//   fail verdict : request serial re-execution, wait for serial_result, write it back, retire.
// Ports:
//   clk, rst (sync, active-low)
//   ready                     : high only in IDLE; verdicts are accepted only then
//   commit_ok / commit_fail   : verdict (fail wins), block_id / result_in sampled with it
//   rf_we / rf_waddr / rf_wdata : architectural register-file write port
//   serial_req / serial_block_id / serial_ack / serial_done / serial_result : serial core handshake
//   retire_valid / retire_block_id / retire_serial : one-cycle retire pulse
//   err_protocol / err_timeout : sticky error flags
// All outputs except ready are registered.
module ife_commit_sequencer
  import ife_pkg::*;
#(
  parameter int unsigned BLOCK_ID_WIDTH = 8,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned REG_WIDTH      = 64,
  parameter int unsigned SERIAL_TIMEOUT = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                ready,
  input  logic                                commit_ok,
  input  logic                                commit_fail,
  input  logic [BLOCK_ID_WIDTH-1:0]           block_id,
  input  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  result_in,
  output logic                                rf_we,
  output logic [idx_width(NUM_REGS)-1:0]      rf_waddr,
  output logic [REG_WIDTH-1:0]                rf_wdata,
  output logic                                serial_req,
  output logic [BLOCK_ID_WIDTH-1:0]           serial_block_id,
  input  logic                                serial_ack,
  input  logic                                serial_done,
  input  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  serial_result,
  output logic                                retire_valid,
  output logic [BLOCK_ID_WIDTH-1:0]           retire_block_id,
  output logic                                retire_serial,
  output logic                                err_protocol,
  output logic                                err_timeout
);

  localparam int unsigned IDX_W = idx_width(NUM_REGS);
  localparam int unsigned CNT_W = $clog2(SERIAL_TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SERIAL_TIMEOUT - 1);

  ife_cseq_state_t state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BLOCK_ID_WIDTH-1:0] blk_q, blk_d;
  logic                      ser_q, ser_d;

  logic                      we_d;
  logic [IDX_W-1:0]          waddr_d;
  logic [REG_WIDTH-1:0]      wdata_d;
  logic                      req_d;
  logic [BLOCK_ID_WIDTH-1:0] sbid_d;
  logic                      rv_d;
  logic [BLOCK_ID_WIDTH-1:0] rbid_d;
  logic                      rser_d;
  logic                      errp_d;
  logic                      errt_d;

  logic                               snap_load;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0] snap_vec;
  logic [IDX_W-1:0]                   snap_rd_idx;
  logic [REG_WIDTH-1:0]               snap_rd_data;
  logic                               first_write;

  ife_reg_snapshot #(
    .NUM_REGS  (NUM_REGS),
    .REG_WIDTH (REG_WIDTH)
  ) u_snapshot (
    .clk       (clk),
    .load      (snap_load),
    .load_data (snap_vec),
    .rd_idx    (snap_rd_idx),
    .rd_data   (snap_rd_data)
  );

  // Prefetch the register after the one currently on the write port.
  assign snap_rd_idx = idx_q + IDX_W'(1);

  assign ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    ser_d       = ser_q;
    we_d        = 1'b0;
    waddr_d     = '0;
    wdata_d     = '0;
    req_d       = 1'b0;
    sbid_d      = serial_block_id;
    rv_d        = 1'b0;
    rbid_d      = retire_block_id;
    rser_d      = 1'b0;
    errp_d      = err_protocol | ((commit_ok | commit_fail) & (state_q != IDLE));
    errt_d      = err_timeout;
    snap_load   = 1'b0;
    snap_vec    = result_in;
    first_write = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (commit_fail) begin
          state_d = SREQ;
          blk_d   = block_id;
          ser_d   = 1'b1;
          req_d   = 1'b1;
          sbid_d  = block_id;
        end else if (commit_ok) begin
          state_d     = WB;
          blk_d       = block_id;
          ser_d       = 1'b0;
          snap_load   = 1'b1;
          snap_vec    = result_in;
          first_write = 1'b1;
        end
      end
      SREQ: begin
        if (serial_ack) begin
          if (serial_done) begin
            state_d     = WB;
            snap_load   = 1'b1;
            snap_vec    = serial_result;
            first_write = 1'b1;
          end else begin
            state_d = SWAIT;
            cnt_d   = '0;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      SWAIT: begin
        if (serial_done) begin
          state_d     = WB;
          snap_load   = 1'b1;
          snap_vec    = serial_result;
          first_write = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          errt_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          rv_d    = 1'b1;
          rbid_d  = blk_q;
          rser_d  = ser_q;
        end else begin
          idx_d   = snap_rd_idx;
          we_d    = 1'b1;
          waddr_d = snap_rd_idx;
          wdata_d = snap_rd_data;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The write port is registered, so x1 must be issued on the same edge the
    // snapshot loads; its data is taken from the vector being captured.
    if (first_write) begin
      idx_d   = IDX_FIRST;
      we_d    = 1'b1;
      waddr_d = IDX_FIRST;
      wdata_d = snap_vec[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      cnt_q           <= '0;
      blk_q           <= '0;
      ser_q           <= 1'b0;
      rf_we           <= 1'b0;
      rf_waddr        <= '0;
      rf_wdata        <= '0;
      serial_req      <= 1'b0;
      serial_block_id <= '0;
      retire_valid    <= 1'b0;
      retire_block_id <= '0;
      retire_serial   <= 1'b0;
      err_protocol    <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      blk_q           <= blk_d;
      ser_q           <= ser_d;
      rf_we           <= we_d;
      rf_waddr        <= waddr_d;
      rf_wdata        <= wdata_d;
      serial_req      <= req_d;
      serial_block_id <= sbid_d;
      retire_valid    <= rv_d;
      retire_block_id <= rbid_d;
      retire_serial   <= rser_d;
      err_protocol    <= errp_d;
      err_timeout     <= errt_d;
    end
  end

endmodule
